// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush clears, N-way operand
// forwarding and saturating stall/flush counters for the RV32I core.
// Every in-flight instruction is tracked in a shift register of slot records
// running from EX (slot 0) to the last write-back slot (slot DEPTH-1).
module pipe_hazard_ctrl #(
    parameter int DEPTH     = 3,
    parameter int ALU_READY = 1,
    parameter int LD_READY  = 2,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_we,
    input  logic             de_ld,
    input  logic             flush,
    output logic             stall,
    output logic             clr_de,
    output logic             clr_ex,
    output logic [SEL_W-1:0] fwd_a,
    output logic [SEL_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } slot_t;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             found1, found2;
    logic             stall_rs1, stall_rs2;
    logic             stall_now;
    logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;

    // A slot produces register r only if it really writes it; x0 never counts.
    function automatic logic writes_reg(logic valid, logic we, logic [4:0] rd,
                                        logic [4:0] r);
        return valid & we & (rd == r) & (r != 5'd0);
    endfunction

    // Load-use stall: look at the youngest producer of each used decode source.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see the
        // updated value; every variable gets a default first so no latch forms.
        found1    = 1'b0;
        found2    = 1'b0;
        stall_rs1 = 1'b0;
        stall_rs2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found1 && de_use_rs1 &&
                writes_reg(slot_q[k].valid, slot_q[k].we, slot_q[k].rd, de_rs1)) begin
                found1    = 1'b1;
                stall_rs1 = (k + 1) < (slot_q[k].ld ? LD_READY : ALU_READY);
            end
            if (!found2 && de_use_rs2 &&
                writes_reg(slot_q[k].valid, slot_q[k].we, slot_q[k].rd, de_rs2)) begin
                found2    = 1'b1;
                stall_rs2 = (k + 1) < (slot_q[k].ld ? LD_READY : ALU_READY);
            end
        end
        stall_now = de_valid & ~flush & (stall_rs1 | stall_rs2);
    end

    // Forwarding selects for the instruction in EX: lowest producing slot wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (slot_q[0].valid && slot_q[0].use1 &&
                writes_reg(slot_q[k].valid, slot_q[k].we, slot_q[k].rd, slot_q[0].rs1))
                fwd_a_sel = SEL_W'(k);
            if (slot_q[0].valid && slot_q[0].use2 &&
                writes_reg(slot_q[k].valid, slot_q[k].we, slot_q[k].rd, slot_q[0].rs2))
                fwd_b_sel = SEL_W'(k);
        end
    end

    // Next slot state: everything moves one stage; EX takes decode or a bubble.
    always_comb begin
        slot_d[0] = '0;
        if (de_valid && !stall_now && !flush) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].rd    = de_rd;
            slot_d[0].we    = de_we;
            slot_d[0].ld    = de_ld;
            slot_d[0].rs1   = de_rs1;
            slot_d[0].rs2   = de_rs2;
            slot_d[0].use1  = de_use_rs1;
            slot_d[0].use2  = de_use_rs2;
        end
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k - 1];
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_now && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the whole slot array is reset, not only the valid bits, so the
        // register comparators never see X after reset.
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall     = stall_now;
    assign clr_de    = flush;
    assign clr_ex    = flush | stall_now;
    assign fwd_a     = fwd_a_sel;
    assign fwd_b     = fwd_b_sel;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a sequential vector table for the main
// hazard/forwarding behaviour, plus hand-written counter saturation,
// mid-stall reset and deep-pipeline (LD_READY=3) sequences.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_valid;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic        de_use_rs1, de_use_rs2, de_we, de_ld, flush;

    logic        stall, clr_de, clr_ex;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_clr_de, s_clr_ex;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic        d_stall, d_clr_de, d_clr_ex;
    logic [1:0]  d_fwd_a, d_fwd_b;
    logic [15:0] d_stall_cnt, d_flush_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd), .de_we(de_we),
        .de_ld(de_ld), .flush(flush), .stall(stall), .clr_de(clr_de), .clr_ex(clr_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd), .de_we(de_we),
        .de_ld(de_ld), .flush(flush), .stall(s_stall), .clr_de(s_clr_de), .clr_ex(s_clr_ex),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    pipe_hazard_ctrl #(.DEPTH(4), .LD_READY(3)) dut_deep (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd), .de_we(de_we),
        .de_ld(de_ld), .flush(flush), .stall(d_stall), .clr_de(d_clr_de), .clr_ex(d_clr_ex),
        .fwd_a(d_fwd_a), .fwd_b(d_fwd_b), .stall_cnt(d_stall_cnt), .flush_cnt(d_flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic instr_t i_nop();
        instr_t i;
        i = '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};
        return i;
    endfunction

    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        instr_t i;
        i = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, we: 1'b1, ld: 1'b0};
        return i;
    endfunction

    // Immediate form: rs2 field carries junk equal to rs1 but is not used.
    function automatic instr_t i_addi(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = '{v: 1'b1, rs1: rs1, rs2: rs1, u1: 1'b1, u2: 1'b0, rd: rd, we: 1'b1, ld: 1'b0};
        return i;
    endfunction

    function automatic instr_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i = '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, we: 1'b1, ld: 1'b1};
        return i;
    endfunction

    function automatic vec_t mk(input instr_t ins, input logic fl, input logic st,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v = '{ins: ins, fl: fl, e_stall: st, e_fa: fa, e_fb: fb};
        return v;
    endfunction

    task automatic drive(input instr_t ins, input logic fl);
        de_valid   = ins.v;
        de_rs1     = ins.rs1;
        de_rs2     = ins.rs2;
        de_use_rs1 = ins.u1;
        de_use_rs2 = ins.u2;
        de_rd      = ins.rd;
        de_we      = ins.we;
        de_ld      = ins.ld;
        flush      = fl;
    endtask

    // Drive at the falling edge, sample 1 time unit later, well before the rising edge.
    task automatic step(input instr_t ins, input logic fl);
        @(negedge clk);
        drive(ins, fl);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential table: each row is one decode cycle; a stalled instruction
        // is presented again on the next row, as the held FE/DE register would.
        vecs[0]  = mk(i_alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[1]  = mk(i_alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[2]  = mk(i_nop(),                 1'b0, 1'b0, 2'd1, 2'd1);
        vecs[3]  = mk(i_lw(5'd7, 5'd1),        1'b0, 1'b0, 2'd0, 2'd0);
        vecs[4]  = mk(i_alu(5'd8, 5'd7, 5'd0), 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[5]  = mk(i_alu(5'd8, 5'd7, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[6]  = mk(i_nop(),                 1'b0, 1'b0, 2'd2, 2'd0);
        vecs[7]  = mk(i_lw(5'd7, 5'd1),        1'b0, 1'b0, 2'd0, 2'd0);
        vecs[8]  = mk(i_addi(5'd7, 5'd7),      1'b0, 1'b1, 2'd0, 2'd0);
        vecs[9]  = mk(i_addi(5'd7, 5'd7),      1'b0, 1'b0, 2'd0, 2'd0);
        vecs[10] = mk(i_alu(5'd9, 5'd7, 5'd7), 1'b0, 1'b0, 2'd2, 2'd0);
        vecs[11] = mk(i_nop(),                 1'b0, 1'b0, 2'd1, 2'd1);
        vecs[12] = mk(i_lw(5'd4, 5'd1),        1'b0, 1'b0, 2'd0, 2'd0);
        vecs[13] = mk(i_alu(5'd3, 5'd4, 5'd2), 1'b1, 1'b0, 2'd0, 2'd0);
        vecs[14] = mk(i_alu(5'd10, 5'd3, 5'd4), 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[15] = mk(i_nop(),                 1'b0, 1'b0, 2'd0, 2'd2);
        vecs[16] = mk(i_lw(5'd0, 5'd1),        1'b0, 1'b0, 2'd0, 2'd0);
        vecs[17] = mk(i_alu(5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[18] = mk(i_nop(),                 1'b0, 1'b0, 2'd0, 2'd0);

        // Reset held for two rising edges.
        rst = 1'b1;
        drive(i_nop(), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", stall, 0);
        check("reset clr_de", clr_de, 0);
        check("reset clr_ex", clr_ex, 0);
        check("reset fwd_a", fwd_a, 0);
        check("reset fwd_b", fwd_b, 0);
        check("reset stall_cnt", stall_cnt, 0);
        check("reset flush_cnt", flush_cnt, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].ins, vecs[i].fl);
            check($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
            check($sformatf("v%0d clr_de", i), clr_de, vecs[i].fl);
            check($sformatf("v%0d clr_ex", i), clr_ex, vecs[i].fl | vecs[i].e_stall);
            check($sformatf("v%0d fwd_a", i), fwd_a, vecs[i].e_fa);
            check($sformatf("v%0d fwd_b", i), fwd_b, vecs[i].e_fb);
        end
        @(negedge clk);
        drive(i_nop(), 1'b0);
        #1;
        check("table stall_cnt", stall_cnt, 2);
        check("table flush_cnt", flush_cnt, 1);
        check("table sat stall_cnt", s_stall_cnt, 2);

        // Three more load-use pairs and three flush cycles: 5 stalls, 4 flushes.
        for (int p = 0; p < 3; p++) begin
            step(i_lw(5'd7, 5'd1), 1'b0);
            step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
            check($sformatf("pair%0d stall", p), stall, 1);
            step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
            check($sformatf("pair%0d release", p), stall, 0);
        end
        for (int f = 0; f < 3; f++) begin
            step(i_nop(), 1'b1);
        end
        step(i_nop(), 1'b0);
        check("sat stall_cnt wide", stall_cnt, 5);
        check("sat stall_cnt narrow", s_stall_cnt, 3);
        check("sat flush_cnt wide", flush_cnt, 4);
        check("sat flush_cnt narrow", s_flush_cnt, 3);

        // Reset asserted while a load-use stall is visible.
        step(i_lw(5'd7, 5'd1), 1'b0);
        step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
        check("rst_mid pre stall", stall, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid stall", stall, 0);
        check("rst_mid clr_ex", clr_ex, 0);
        check("rst_mid stall_cnt", stall_cnt, 0);
        check("rst_mid flush_cnt", flush_cnt, 0);

        // Deep variant (DEPTH=4, LD_READY=3): two stall cycles, then forward from slot 3.
        step(i_lw(5'd7, 5'd1), 1'b0);
        check("deep lw stall", d_stall, 0);
        step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
        check("deep stall c1", d_stall, 1);
        check("deep clr_ex c1", d_clr_ex, 1);
        step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
        check("deep stall c2", d_stall, 1);
        step(i_alu(5'd8, 5'd7, 5'd0), 1'b0);
        check("deep stall c3", d_stall, 0);
        step(i_nop(), 1'b0);
        check("deep fwd_a", d_fwd_a, 3);
        check("deep fwd_b", d_fwd_b, 0);
        check("deep stall_cnt", d_stall_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
